sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port 1RW OpenRAM macro (512 x 65 bits: 64 data bits, 8 byte-write masks, 1 spare bit).
- After reset it zero-fills the whole macro. It then grants at most one request per cycle and returns read data one cycle after acceptance.
- Sits between user-project masters (e.g. a Wishbone slave and a DMA engine) and the macro, on the macro's clock.

Parameters:
- ADDR_WIDTH, 9, macro address width; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 65, macro word width (64 data bits plus 1 spare bit at index DATA_WIDTH-1).
- NUM_WMASKS, 8, byte-mask count; covers bits [8*NUM_WMASKS-1:0].

Ports:
- wb_clk_i  in  1  clock; also drives the macro clk0 externally.
- wb_rst_i  in  1  synchronous active-high reset.
- init_done  out  1  high once zero-fill has completed.
- rN_valid  in  1  request from requester N (N=0,1).
- rN_ready  out  1  request accepted this cycle.
- rN_we  in  1  1=write, 0=read.
- rN_wmask  in  NUM_WMASKS  byte write enables.
- rN_spare_we  in  1  spare-bit write enable.
- rN_addr  in  ADDR_WIDTH  word address.
- rN_wdata  in  DATA_WIDTH  write data.
- rN_rvalid  out  1  one-cycle read-data strobe.
- rN_rdata  out  DATA_WIDTH  read data.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro byte mask.
- sram_spare_wen0  out  1  macro spare-bit enable.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values:
  - State=INIT, fill counter=0, rr pointer=0 (requester 0 has priority first).
  - init_done=0, rN_ready=0, rN_rvalid=0, rN_rdata=0.
- Reset asserted mid-fill or mid-operation: same reset values apply. Fill restarts at address 0, and any in-flight read response is dropped (rvalid stays 0).
- FSM states: INIT -> RUN.
- INIT:
  - Each cycle drives csb0=0, web0=0, wmask0=all ones, spare_wen0=1, addr0=counter, din0=0.
  - Counter increments every cycle. After writing address depth-1, go to RUN; init_done=1 from the next cycle.
  - The fill takes exactly 512 cycles. rN_ready=0 throughout.
- RUN, macro outputs:
  - The macro ports are combinational from the grant. The macro samples them on the same rising edge that completes the rN_valid&rN_ready handshake.
  - No grant: csb0=1; other macro outputs hold their last values.
- RUN, arbitration:
  - rN_ready is combinational: asserted when in RUN and requester N wins.
  - Only one valid requester: it wins.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates only on a grant, so a waiting requester is served within 2 cycles.
  - rN_ready never asserts without rN_valid.
- Grant mapping: web0 = ~rN_we. For reads, wmask0=0 and spare_wen0=0, regardless of the requester's inputs.
- Read latency:
  - The macro registers the read at edge E0 and presents dout before E1 (valid when half-period > macro delay of 3).
  - At E1 the controller captures sram_dout0 into rN_rdata of the requester granted at E0.
  - rN_rvalid is high for exactly the cycle after E1.
  - Throughput is one operation per cycle, with back-to-back reads pipelined.
- Responses have no backpressure; requesters must sink rvalid.
- rN_rdata holds its value until the next read response to that requester.
- Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data, because the macro writes on the negedge before the next read sample.

Decomposition:
- Package sram_arb_pkg: state enum (ST_INIT, ST_RUN), ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults, spare-bit index constant.
- One sub-module: rr_arb2 (combinational two-way round-robin grant with registered last-grant pointer).
- Fill counter, response pipeline and macro mux stay in the top module.

Test Plan:
- Reset, then idle -> init_done rises exactly 513 cycles after reset deassert; a read of address 0x1FF then returns 65'h0.
- r0 writes addr 0x005, data 64'hDEADBEEF_CAFEF00D, wmask 8'hFF, spare_we=1 with spare bit 1; next cycle r0 reads 0x005 -> r0_rvalid one cycle after the read acceptance, r0_rdata = {1'b1, 64'hDEADBEEF_CAFEF00D}.
- Write wmask 8'h0F, data 64'h11111111_22222222, to a zeroed word; then read -> 64'h00000000_22222222, spare bit unchanged 0.
- r0 and r1 both hold valid for 6 cycles -> grants alternate r0, r1, r0, r1...; each rvalid routes only to its owner, with correct addresses.
- Reads on 4 consecutive cycles to 0x010..0x013, preloaded with 1..4 -> rvalid high 4 consecutive cycles, rdata 1, 2, 3, 4.
- Assert wb_rst_i at fill count 200 -> init_done stays 0, fill restarts at address 0, no rN_ready until the full 512-cycle fill completes.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and default geometry for the two-requester
//                round-robin arbiter in front of a 512 x 65 1RW SRAM macro.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_ADDR_WIDTH = 9;
    localparam int c_DATA_WIDTH = 65;
    localparam int c_NUM_WMASKS = 8;
    // The spare bit sits above the byte-masked data bits.
    localparam int c_SPARE_BIT  = c_DATA_WIDTH - 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_rr_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin grant. A one-bit pointer
//                names the requester that wins a tie; it flips to the other
//                requester whenever a grant is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_ptr_q;
    logic       w_ptr_d;
    logic [1:0] w_gnt;

    // Grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt = r_ptr_q ? 2'b10 : 2'b01;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    // Pointer moves only on a grant, handing priority to the other side.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_gnt[0]) begin
            w_ptr_d = 1'b1;
        end else if (w_gnt[1]) begin
            w_ptr_d = 1'b0;
        end
    end

    // Pointer register; requester 0 holds priority out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= 1'b0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rr_arbiter
//  Description : Zero-fills a 1RW SRAM macro after reset, then arbitrates two
//                requesters round-robin onto it, one operation per cycle,
//                returning read data one cycle after the macro samples a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NUM_WMASKS = c_NUM_WMASKS
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    output logic                  init_done,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [NUM_WMASKS-1:0] r0_wmask,
    input  logic                  r0_spare_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [NUM_WMASKS-1:0] r1_wmask,
    input  logic                  r1_spare_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic                  sram_spare_wen0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    arb_state_t            r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] r_fill_q, w_fill_d;
    logic                  r_init_done_q, w_init_done_d;

    logic [1:0]            w_gnt;
    logic                  w_arb_en;
    logic [1:0]            r_rd_pend_q, w_rd_pend_d;
    logic [1:0]            r_rvalid_q;
    logic [DATA_WIDTH-1:0] r_rdata0_q, w_rdata0_d;
    logic [DATA_WIDTH-1:0] r_rdata1_q, w_rdata1_d;

    logic                  w_csb, w_web, w_spare;
    logic [NUM_WMASKS-1:0] w_wmask;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic                  r_web_q, r_spare_q;
    logic [NUM_WMASKS-1:0] r_wmask_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_din_q;

    // Nothing is accepted while reset is applied so no macro access slips in.
    assign w_arb_en = (r_state_q == ST_RUN) && !wb_rst_i;

    rr_arb2 u_rr_arb2 (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .i_en  (w_arb_en),
        .i_req ({r1_valid, r0_valid}),
        .o_gnt (w_gnt)
    );

    // Fill sequencer: one word per cycle, leave INIT after the last address.
    always_comb begin
        w_state_d = r_state_q;
        w_fill_d  = r_fill_q;
        if (r_state_q == ST_INIT) begin
            w_fill_d = r_fill_q + ADDR_WIDTH'(1);
            if (r_fill_q == {ADDR_WIDTH{1'b1}}) begin
                w_state_d = ST_RUN;
            end
        end
        w_init_done_d = (r_state_q == ST_RUN);
    end

    // Response pipeline: remember who issued a read, capture dout next edge.
    always_comb begin
        w_rd_pend_d = {w_gnt[1] & ~r1_we, w_gnt[0] & ~r0_we};
        w_rdata0_d  = r_rdata0_q;
        w_rdata1_d  = r_rdata1_q;
        if (r_rd_pend_q[0]) begin
            w_rdata0_d = sram_dout0;
        end
        if (r_rd_pend_q[1]) begin
            w_rdata1_d = sram_dout0;
        end
    end

    // Macro mux: fill pattern, granted request, or deselect holding last values.
    always_comb begin
        w_csb   = 1'b1;
        w_web   = r_web_q;
        w_wmask = r_wmask_q;
        w_spare = r_spare_q;
        w_addr  = r_addr_q;
        w_din   = r_din_q;
        if (r_state_q == ST_INIT) begin
            w_csb   = 1'b0;
            w_web   = 1'b0;
            w_wmask = {NUM_WMASKS{1'b1}};
            w_spare = 1'b1;
            w_addr  = r_fill_q;
            w_din   = '0;
        end else if (w_gnt[0]) begin
            w_csb   = 1'b0;
            w_web   = ~r0_we;
            w_wmask = r0_we ? r0_wmask : '0;
            w_spare = r0_we & r0_spare_we;
            w_addr  = r0_addr;
            w_din   = r0_wdata;
        end else if (w_gnt[1]) begin
            w_csb   = 1'b0;
            w_web   = ~r1_we;
            w_wmask = r1_we ? r1_wmask : '0;
            w_spare = r1_we & r1_spare_we;
            w_addr  = r1_addr;
            w_din   = r1_wdata;
        end
    end

    // State, fill counter, response pipeline and macro hold registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q     <= ST_INIT;
            r_fill_q      <= '0;
            r_init_done_q <= 1'b0;
            r_rd_pend_q   <= 2'b00;
            r_rvalid_q    <= 2'b00;
            r_rdata0_q    <= '0;
            r_rdata1_q    <= '0;
            r_web_q       <= 1'b1;
            r_wmask_q     <= '0;
            r_spare_q     <= 1'b0;
            r_addr_q      <= '0;
            r_din_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_fill_q      <= w_fill_d;
            r_init_done_q <= w_init_done_d;
            r_rd_pend_q   <= w_rd_pend_d;
            r_rvalid_q    <= r_rd_pend_q;
            r_rdata0_q    <= w_rdata0_d;
            r_rdata1_q    <= w_rdata1_d;
            r_web_q       <= w_web;
            r_wmask_q     <= w_wmask;
            r_spare_q     <= w_spare;
            r_addr_q      <= w_addr;
            r_din_q       <= w_din;
        end
    end

    assign init_done       = r_init_done_q;
    assign r0_ready        = w_gnt[0];
    assign r1_ready        = w_gnt[1];
    assign r0_rvalid       = r_rvalid_q[0];
    assign r1_rvalid       = r_rvalid_q[1];
    assign r0_rdata        = r_rdata0_q;
    assign r1_rdata        = r_rdata1_q;
    assign sram_csb0       = w_csb;
    assign sram_web0       = w_web;
    assign sram_wmask0     = w_wmask;
    assign sram_spare_wen0 = w_spare;
    assign sram_addr0      = w_addr;
    assign sram_din0       = w_din;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_rr_arbiter
//  Description : Self-checking bench for sram_rr_arbiter with a behavioural
//                1RW macro (registered inputs, negedge write, delayed dout).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rr_arbiter;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        init_done;
    logic        r0_valid, r0_ready, r0_we, r0_spare_we, r0_rvalid;
    logic [7:0]  r0_wmask;
    logic [8:0]  r0_addr;
    logic [64:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_spare_we, r1_rvalid;
    logic [7:0]  r1_wmask;
    logic [8:0]  r1_addr;
    logic [64:0] r1_wdata, r1_rdata;
    logic        sram_csb0, sram_web0, sram_spare_wen0;
    logic [7:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [64:0] sram_din0, sram_dout0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_rr_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .init_done(init_done),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_wmask(r0_wmask),
        .r0_spare_we(r0_spare_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_wmask(r1_wmask),
        .r1_spare_we(r1_spare_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Behavioural macro: inputs registered at posedge, write at negedge, read data 3 after posedge.
    logic [64:0] mem [512];
    logic        m_csb = 1'b1;
    logic        m_web = 1'b1;
    logic        m_sp;
    logic [7:0]  m_mask;
    logic [8:0]  m_addr;
    logic [64:0] m_din;

    always @(posedge clk) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_sp   <= sram_spare_wen0;
        m_mask <= sram_wmask0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb && !m_web) begin
            for (int b = 0; b < 8; b++) begin
                if (m_mask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
            end
            if (m_sp) mem[m_addr][64] <= m_din[64];
        end
    end

    always @(posedge clk) begin
        #3;
        if (!m_csb && m_web) sram_dout0 = mem[m_addr];
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic        we;
        logic [7:0]  m;
        logic        swe;
        logic [8:0]  a;
        logic [64:0] d;
    } req_t;

    typedef struct {
        req_t        q0;
        req_t        q1;
        logic [1:0]  rdy;
        logic [1:0]  rv;
        logic [64:0] rd0;
        logic [64:0] rd1;
    } vec_t;

    function automatic req_t wr(input logic [8:0] a, input logic [64:0] d,
                                input logic [7:0] m, input logic swe);
        req_t r;
        r.v = 1'b1; r.we = 1'b1; r.m = m; r.swe = swe; r.a = a; r.d = d;
        return r;
    endfunction

    // Reads carry junk masks/data so the bench sees them forced off at the macro.
    function automatic req_t rd(input logic [8:0] a);
        req_t r;
        r.v = 1'b1; r.we = 1'b0; r.m = 8'hFF; r.swe = 1'b1; r.a = a; r.d = '1;
        return r;
    endfunction

    function automatic req_t no();
        req_t r;
        r.v = 1'b0; r.we = 1'b0; r.m = 8'h00; r.swe = 1'b0; r.a = 9'h0; r.d = '0;
        return r;
    endfunction

    function automatic vec_t mk(input req_t q0, input req_t q1, input logic [1:0] rdy,
                                input logic [1:0] rv, input logic [64:0] rd0,
                                input logic [64:0] rd1);
        vec_t t;
        t.q0 = q0; t.q1 = q1; t.rdy = rdy; t.rv = rv; t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    task automatic drive(input req_t q0, input req_t q1);
        r0_valid = q0.v; r0_we = q0.we; r0_wmask = q0.m; r0_spare_we = q0.swe;
        r0_addr  = q0.a; r0_wdata = q0.d;
        r1_valid = q1.v; r1_we = q1.we; r1_wmask = q1.m; r1_spare_we = q1.swe;
        r1_addr  = q1.a; r1_wdata = q1.d;
    endtask

    // Waits for the zero-fill, checking its drive pattern and that nothing is granted meanwhile.
    task automatic wait_fill();
        int cyc;
        bit bad_rdy, bad_fill;
        cyc = 0; bad_rdy = 1'b0; bad_fill = 1'b0;
        drive(rd(9'h1FF), rd(9'h1FE));
        #1;
        chk("fill start addr", {56'h0, sram_addr0}, 65'h0);
        while (init_done !== 1'b1 && cyc < 600) begin
            if (cyc <= 510 && (r0_ready !== 1'b0 || r1_ready !== 1'b0)) bad_rdy = 1'b1;
            if (cyc < 512 && (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 8'hFF ||
                sram_spare_wen0 !== 1'b1 || sram_din0 !== 65'h0 || sram_addr0 !== cyc[8:0]))
                bad_fill = 1'b1;
            if (cyc == 510) drive(no(), no());
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready during fill", {64'h0, bad_rdy}, 65'h0);
        chk("fill drive pattern", {64'h0, bad_fill}, 65'h0);
        chk("init_done latency", 65'(cyc), 65'd513);
    endtask

    localparam int NV = 25;
    localparam logic [64:0] DEAD = {1'b1, 64'hDEADBEEF_CAFEF00D};
    localparam logic [64:0] PART = {1'b0, 64'h00000000_22222222};

    vec_t tv [NV];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = mk(rd(9'h1FF), no(), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[1]  = mk(wr(9'h005, DEAD, 8'hFF, 1'b1), no(), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[2]  = mk(rd(9'h005), no(), 2'b01, 2'b01, 65'h0, 65'h0);
        tv[3]  = mk(wr(9'h020, {1'b1, 64'h11111111_22222222}, 8'h0F, 1'b0), no(),
                    2'b01, 2'b00, 65'h0, 65'h0);
        tv[4]  = mk(rd(9'h020), no(), 2'b01, 2'b01, DEAD, 65'h0);
        tv[5]  = mk(no(), wr(9'h010, 65'd1, 8'hFF, 1'b1), 2'b10, 2'b00, 65'h0, 65'h0);
        tv[6]  = mk(wr(9'h011, 65'd2, 8'hFF, 1'b1), wr(9'h012, 65'd3, 8'hFF, 1'b1),
                    2'b01, 2'b01, PART, 65'h0);
        tv[7]  = mk(wr(9'h013, 65'd4, 8'hFF, 1'b1), wr(9'h012, 65'd3, 8'hFF, 1'b1),
                    2'b10, 2'b00, 65'h0, 65'h0);
        tv[8]  = mk(wr(9'h013, 65'd4, 8'hFF, 1'b1), no(), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[9]  = mk(rd(9'h010), no(), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[10] = mk(rd(9'h011), no(), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[11] = mk(rd(9'h012), no(), 2'b01, 2'b01, 65'd1, 65'h0);
        tv[12] = mk(rd(9'h013), no(), 2'b01, 2'b01, 65'd2, 65'h0);
        tv[13] = mk(no(), no(), 2'b00, 2'b01, 65'd3, 65'h0);
        tv[14] = mk(no(), no(), 2'b00, 2'b01, 65'd4, 65'h0);
        tv[15] = mk(no(), rd(9'h020), 2'b10, 2'b00, 65'h0, 65'h0);
        tv[16] = mk(rd(9'h005), rd(9'h010), 2'b01, 2'b00, 65'h0, 65'h0);
        tv[17] = mk(rd(9'h005), rd(9'h010), 2'b10, 2'b10, 65'h0, PART);
        tv[18] = mk(rd(9'h005), rd(9'h010), 2'b01, 2'b01, DEAD, 65'h0);
        tv[19] = mk(rd(9'h005), rd(9'h010), 2'b10, 2'b10, 65'h0, 65'd1);
        tv[20] = mk(rd(9'h005), rd(9'h010), 2'b01, 2'b01, DEAD, 65'h0);
        tv[21] = mk(rd(9'h005), rd(9'h010), 2'b10, 2'b10, 65'h0, 65'd1);
        tv[22] = mk(no(), no(), 2'b00, 2'b01, DEAD, 65'h0);
        tv[23] = mk(no(), no(), 2'b00, 2'b10, 65'h0, 65'd1);
        tv[24] = mk(no(), no(), 2'b00, 2'b00, 65'h0, 65'h0);

        // Reset state, with a request pending to show it is not accepted.
        drive(no(), no());
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drive(rd(9'h000), rd(9'h001));
        #1;
        chk("reset ready", {63'h0, r1_ready, r0_ready}, 65'h0);
        chk("reset init_done", {64'h0, init_done}, 65'h0);
        chk("reset rvalid", {63'h0, r1_rvalid, r0_rvalid}, 65'h0);
        chk("reset r0_rdata", r0_rdata, 65'h0);
        chk("reset r1_rdata", r1_rdata, 65'h0);
        wb_rst_i = 1'b0;
        wait_fill();

        // Directed vector table: responses sampled first, then the row's requests.
        for (int i = 0; i < NV; i++) begin
            req_t g;
            chk($sformatf("row%0d rvalid", i), {63'h0, r1_rvalid, r0_rvalid}, {63'h0, tv[i].rv});
            if (tv[i].rv[0]) chk($sformatf("row%0d r0_rdata", i), r0_rdata, tv[i].rd0);
            if (tv[i].rv[1]) chk($sformatf("row%0d r1_rdata", i), r1_rdata, tv[i].rd1);
            drive(tv[i].q0, tv[i].q1);
            #1;
            chk($sformatf("row%0d ready", i), {63'h0, r1_ready, r0_ready}, {63'h0, tv[i].rdy});
            chk($sformatf("row%0d csb0", i), {64'h0, sram_csb0}, {64'h0, ~|tv[i].rdy});
            if (tv[i].rdy != 2'b00) begin
                g = tv[i].rdy[0] ? tv[i].q0 : tv[i].q1;
                chk($sformatf("row%0d addr0", i), {56'h0, sram_addr0}, {56'h0, g.a});
                chk($sformatf("row%0d web0", i), {64'h0, sram_web0}, {64'h0, ~g.we});
                chk($sformatf("row%0d wmask0", i), {57'h0, sram_wmask0},
                    {57'h0, (g.we ? g.m : 8'h00)});
                chk($sformatf("row%0d spare_wen0", i), {64'h0, sram_spare_wen0},
                    {64'h0, g.we & g.swe});
            end
            @(posedge clk); #1;
        end
        drive(no(), no());

        // Read data holds until the owner's next response.
        chk("r0_rdata hold", r0_rdata, DEAD);
        chk("r1_rdata hold", r1_rdata, 65'd1);

        // Reset with a read in flight: its response is dropped.
        drive(rd(9'h005), no());
        #1;
        chk("inflight ready", {64'h0, r0_ready}, 65'h1);
        @(posedge clk); #1;
        drive(no(), no());
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        chk("dropped rvalid", {63'h0, r1_rvalid, r0_rvalid}, 65'h0);
        chk("dropped r0_rdata", r0_rdata, 65'h0);
        chk("dropped init_done", {64'h0, init_done}, 65'h0);
        wb_rst_i = 1'b0;

        // Interrupt the fill at count 200; it must restart from address 0.
        repeat (200) @(posedge clk);
        #1;
        chk("fill count 200", {56'h0, sram_addr0}, 65'd200);
        chk("mid-fill init_done", {64'h0, init_done}, 65'h0);
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        chk("refill init_done", {64'h0, init_done}, 65'h0);
        wait_fill();

        // After the refill, a previously written word reads back as zero.
        drive(no(), rd(9'h005));
        #1;
        chk("post-refill ready", {63'h0, r1_ready, r0_ready}, 65'h2);
        @(posedge clk); #1;
        drive(no(), no());
        @(posedge clk); #1;
        chk("post-refill rvalid", {63'h0, r1_rvalid, r0_rvalid}, 65'h2);
        chk("post-refill rdata", r1_rdata, 65'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
